// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: MSB-first word serializer/deserializer with valid/ready host side,
// programmable chip-select setup/hold/idle timing and multi-word bursts under one csn.
module spi_master_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned CLK_DIV    = 4,
  parameter int unsigned CS_SETUP   = 2,
  parameter int unsigned CS_HOLD    = 2,
  parameter int unsigned CS_IDLE    = 2
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_hold_cs,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  busy,
  output logic                  spi_csn,
  output logic                  spi_sck,
  output logic                  spi_mosi,
  input  logic                  spi_miso
);

  localparam int unsigned BW = $clog2(DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE, SETUP, HIGH, LOW, BURST_WAIT, HOLD, GAP
  } state_t;

  state_t                r_state;
  state_t                w_nxt;
  logic [15:0]           r_cnt;
  logic [15:0]           w_dur;
  logic                  w_done;
  logic                  w_ready;
  logic                  w_accept;
  logic                  w_enter_high;
  logic                  w_csn_nxt;
  logic                  w_sck_nxt;
  logic                  w_busy_nxt;
  logic                  r_csn;
  logic                  r_sck;
  logic                  r_busy;
  logic                  r_mosi;
  logic                  r_hold;
  logic                  r_last;
  logic [BW-1:0]         r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [DATA_WIDTH-1:0] r_rx_data;
  logic                  r_rx_valid;

  assign w_done       = (r_cnt == '0);
  assign w_accept     = tx_valid && w_ready;
  assign w_enter_high = (w_nxt == HIGH) && (r_state != HIGH);

  // State register, phase counter and registered SPI/status outputs
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_csn   <= 1'b1;
      r_sck   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      if (w_nxt != r_state) r_cnt <= w_dur;
      else if (!w_done)     r_cnt <= r_cnt - 16'd1;
      r_csn   <= w_csn_nxt;
      r_sck   <= w_sck_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // The LOW state is reused as a trailing half-period after the last bit (r_last),
  // so the frame ends with a full sck-low period before BURST_WAIT or HOLD.
  always_comb begin
    w_nxt = r_state;
    w_dur = '0;
    case (r_state)
      IDLE:       if (w_accept) w_nxt = SETUP;
      SETUP:      if (w_done) w_nxt = HIGH;
      HIGH:       if (w_done) w_nxt = LOW;
      LOW:        if (w_done) begin
                    if (!r_last)    w_nxt = HIGH;
                    else if (r_hold) w_nxt = BURST_WAIT;
                    else            w_nxt = HOLD;
                  end
      BURST_WAIT: if (w_accept) w_nxt = LOW;
                  else if (!tx_valid && !tx_hold_cs) w_nxt = HOLD;
      HOLD:       if (w_done) w_nxt = GAP;
      GAP:        if (w_done) w_nxt = IDLE;
      default:    w_nxt = IDLE;
    endcase
    case (w_nxt)
      SETUP:     w_dur = 16'(CS_SETUP - 1);
      HIGH, LOW: w_dur = 16'(CLK_DIV - 1);
      HOLD:      w_dur = 16'(CS_HOLD - 1);
      GAP:       w_dur = 16'(CS_IDLE - 1);
      default:   w_dur = '0;
    endcase
  end

  always_comb begin
    w_ready    = (r_state == IDLE) || (r_state == BURST_WAIT);
    w_csn_nxt  = (w_nxt == IDLE) || (w_nxt == GAP);
    w_sck_nxt  = (w_nxt == HIGH);
    w_busy_nxt = (w_nxt != IDLE);
  end

  // One shift register serves both directions: miso enters the LSB on sck rise,
  // so the bit due on mosi at the next fall is already in the MSB.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_shift    <= '0;
      r_hold     <= 1'b0;
      r_last     <= 1'b0;
      r_bit      <= '0;
      r_mosi     <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_accept) begin
        r_shift <= tx_data;
        r_hold  <= tx_hold_cs;
        r_bit   <= BW'(DATA_WIDTH - 1);
        r_last  <= 1'b0;
        r_mosi  <= tx_data[DATA_WIDTH-1];
      end else if (w_enter_high) begin
        r_shift <= {r_shift[DATA_WIDTH-2:0], spi_miso};
      end else if (r_state == HIGH && w_done) begin
        if (r_bit != '0) begin
          r_bit  <= r_bit - BW'(1);
          r_mosi <= r_shift[DATA_WIDTH-1];
        end else begin
          r_last     <= 1'b1;
          r_rx_data  <= r_shift;
          r_rx_valid <= 1'b1;
        end
      end else if (r_state == HOLD && w_done) begin
        r_mosi <= 1'b0;
      end
    end
  end

  assign tx_ready = w_ready;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
  assign busy     = r_busy;
  assign spi_csn  = r_csn;
  assign spi_sck  = r_sck;
  assign spi_mosi = r_mosi;

endmodule

// File: doc/spi_master_ctrl.md
Name: spi_master_ctrl

Overview:
- SPI mode-0 master for the FPGA-side link, used to drive the SPI slave ports (csn, sck, mosi in; miso out) of the peer board's system.
- Serializes DATA_WIDTH-bit words, MSB first, on mosi, and captures miso into a parallel word.
- Host side is a valid/ready transmit interface plus a one-cycle rx_valid pulse.
- Supports multi-word bursts with csn held low between words.

Parameters:
- DATA_WIDTH, 8: bits per word, range 2..32.
- CLK_DIV, 4: clk cycles per sck half-period, minimum 1.
- CS_SETUP, 2: clk cycles from csn falling to the first sck rising edge, minimum 1.
- CS_HOLD, 2: clk cycles from the last sck falling edge to csn rising, minimum 1.
- CS_IDLE, 2: minimum clk cycles csn stays high between frames, minimum 1.

Ports:
- clk_clk  in  1  system clock; all logic is on its rising edge.
- reset_reset_n  in  1  asynchronous active-low reset.
- tx_data  in  DATA_WIDTH  word to transmit.
- tx_hold_cs  in  1  sampled with the word; 1 keeps csn low after this word.
- tx_valid  in  1  tx_data and tx_hold_cs are valid.
- tx_ready  out  1  the controller can accept a word.
- rx_data  out  DATA_WIDTH  last received word.
- rx_valid  out  1  one-cycle pulse; rx_data has been updated.
- busy  out  1  high whenever csn is low or the CS_IDLE gap is running.
- spi_csn  out  1  chip select, active low.
- spi_sck  out  1  serial clock, idles low (CPOL=0).
- spi_mosi  out  1  master data out.
- spi_miso  in  1  slave data in.

Behaviour:
- Reset values (asynchronous): spi_csn=1, spi_sck=0, spi_mosi=0, rx_data=0, rx_valid=0, busy=0, state=IDLE, tx_ready=1.
- Reset mid-frame: csn rises immediately, the partial word is discarded and no rx_valid is issued.
- All SPI outputs are registered; miso is sampled directly without synchronizer.
- The word is accepted on a clk edge where tx_valid and tx_ready are both 1.
- On accept, tx_data and tx_hold_cs are latched, and the bit counter is loaded with DATA_WIDTH-1.
- tx_ready is 1 only in IDLE and BURST_WAIT.
- IDLE:
  - On accept: csn becomes 0 and mosi becomes bit[DATA_WIDTH-1] on the next cycle.
  - Go to SETUP.
- SETUP: stays CS_SETUP cycles with sck=0, then goes to HIGH.
- HIGH:
  - sck=1 for CLK_DIV cycles.
  - miso is sampled into the shift register LSB on the clk edge where sck goes 0→1.
- End of HIGH:
  - If the bit counter is not 0: sck=0, mosi takes the next bit, counter decrements, go to LOW.
  - Else: sck=0, then go to BURST_WAIT if the latched hold_cs=1, or to HOLD if it is 0.
- LOW: sck=0 for CLK_DIV cycles, then go to HIGH.
- rx_data/rx_valid: rx_data is loaded and rx_valid pulses for 1 cycle on the same edge that sck falls after the last bit.
- BURST_WAIT:
  - csn stays 0, sck=0, tx_ready=1.
  - On accept: mosi becomes the new MSB and the FSM goes directly to LOW. No SETUP is inserted.
  - If tx_valid=0 and tx_hold_cs=0: go to HOLD.
- HOLD: CS_HOLD cycles with csn=0 and sck=0, then csn=1 and go to GAP.
- GAP: CS_IDLE cycles with csn=1 and tx_ready=0, then go to IDLE.
- Frame timing for a single word: csn low for CS_SETUP + 2·CLK_DIV·DATA_WIDTH − CLK_DIV + CLK_DIV + CS_HOLD cycles. With defaults this is 2+64+2 = 68.
- mosi changes only while sck=0, or at the sck falling edge. It holds the last bit through HOLD, then returns to 0 in GAP.
- tx_valid while not ready: ignored, with no effect on state.
- DATA_WIDTH bits are transmitted exactly; there is no partial-word mode.

Test Plan:
- Single word, defaults:
  - Stimulus: tx_data=0xA5, hold_cs=0; the slave model drives 0x3C MSB first, changing on sck falling edges.
  - Required: mosi bits 1,0,1,0,0,1,0,1 on 8 rising edges; rx_data=0x3C with a single rx_valid pulse.
  - Required: csn low 68 cycles, then high at least 2 cycles before tx_ready=1.
- Burst:
  - Stimulus: words 0x01 and 0x80, hold_cs=1,1, then tx_hold_cs=0.
  - Required: csn low continuously, 16 sck pulses, SETUP appears only once, two rx_valid pulses, then the HOLD and GAP sequence.
- CLK_DIV=1, DATA_WIDTH=16:
  - Stimulus: tx_data=0xFFFF with miso tied 0.
  - Required: sck toggles every cycle with 16 rising edges; mosi stays 1; rx_data=0x0000.
- Reset mid-frame:
  - Stimulus: assert reset_reset_n=0 after the 3rd sck rising edge of 0x55.
  - Required: csn=1, sck=0, mosi=0 asynchronously, no rx_valid, tx_ready=1 after release.
  - Required: the next word 0xC3 transmits correctly.
- Backpressure:
  - Stimulus: hold tx_valid=1 with changing tx_data during a frame.
  - Required: only the word present at the accept edge is sent; tx_ready=0 throughout the frame.
